rssb_exec: RTL and testbench

Execute stage of the 1-bit RSSB (reverse-subtract-and-skip-if-borrow) CPU. It consumes the operand stream that the memory/FIFO stage drives on `ena`/`data`, and owns the accumulator. It computes `mem[a] - acc` and returns the registered `result` and the borrow `flag` to the memory stage. The memory stage writes `result` back to dmem and uses `flag` to invalidate the younger FIFO entry. The block also squashes the skipped instruction internally, so the accumulator never sees it.

---
 rtl/rssb_exec_if.sv | 25 ++
 rtl/rssb_exec.sv | 68 ++++++
 tb/tb_rssb_exec.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rssb_exec_if.sv
// Operand/result bundle between the memory/FIFO stage and the RSSB execute stage.
// The memory stage drives ena/data, and the execute stage returns result/flag one cycle later.
interface rssb_exec_if #(
   parameter int BW = 1
);
   // ena is a valid with no ready: execute accepts every offer (no backpressure), and data is don't-care while ena=0.
   logic          ena;
   logic [BW-1:0] data [1:0];
   logic [BW-1:0] result;
   logic          flag;

   modport master (
      output ena,
      output data,
      input  result,
      input  flag
   );

   modport slave (
      input  ena,
      input  data,
      output result,
      output flag
   );
endinterface

// File: rtl/rssb_exec.sv
// RSSB execute stage: computes mem[a] - acc, owns the accumulator,
// and squashes the instruction that follows a borrow.
module rssb_exec #(
   parameter int BW = 1
) (
   input  logic           clk,
   input  logic           rst,
   rssb_exec_if.slave     bus,
   output logic [1:0]     dbg_state,
   output logic [BW-1:0]  dbg_acc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SKIP = 2'd2
   } state_t;

   state_t        state;
   logic [BW-1:0] acc;
   logic [BW-1:0] result_q;
   logic          flag_q;

   logic [BW-1:0] a_sel;
   logic [BW:0]   diff;
   logic          borrow;

   // The first instruction after reset takes its accumulator seed from data[1].
   always_comb begin
      a_sel  = (state == IDLE) ? bus.data[1] : acc;
      diff   = {1'b0, bus.data[0]} - {1'b0, a_sel};
      borrow = diff[BW];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         acc      <= '0;
         result_q <= '0;
         flag_q   <= 1'b0;
      end else begin
         flag_q <= 1'b0;
         case (state)
            IDLE, RUN: begin
               if (bus.ena) begin
                  acc      <= diff[BW-1:0];
                  result_q <= diff[BW-1:0];
                  flag_q   <= borrow;
                  state    <= borrow ? SKIP : RUN;
               end
            end
            SKIP: begin
               // Squashed slot: nothing visible, the pending skip survives idle cycles.
               if (bus.ena) begin
                  state <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.flag   = flag_q;
   assign dbg_state  = state;
   assign dbg_acc    = acc;

endmodule

// File: tb/tb_rssb_exec.sv
// Randomized scoreboard bench for rssb_exec against a sequential RSSB model.
module tb_rssb_exec;

   localparam int BW = 1;
   localparam int EW = 2 + BW + BW + 1;

   logic          clk;
   logic          rst;
   logic [1:0]    dbg_state;
   logic [BW-1:0] dbg_acc;

   rssb_exec_if #(.BW(BW)) bus ();

   rssb_exec #(.BW(BW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state),
      .dbg_acc   (dbg_acc)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // expected {state, acc, result, flag} per offered cycle
   logic [EW-1:0] exp_q [$];

   // reference model: program-level view of an RSSB machine
   logic          m_seeded;
   logic          m_skip;
   logic [BW-1:0] m_acc;
   logic [BW-1:0] m_result;
   logic          m_flag;

   function automatic logic [1:0] m_state_code();
      if (!m_seeded) return 2'd0;
      if (m_skip)    return 2'd2;
      return 2'd1;
   endfunction

   task automatic model_reset();
      m_seeded = 1'b0;
      m_skip   = 1'b0;
      m_acc    = '0;
      m_result = '0;
      m_flag   = 1'b0;
   endtask

   task automatic model_step(input logic e, input logic [BW-1:0] d0, input logic [BW-1:0] d1);
      int opv;
      int av;
      m_flag = 1'b0;
      if (e) begin
         if (m_skip) begin
            m_skip = 1'b0;
         end else begin
            opv      = int'(d0);
            av       = m_seeded ? int'(m_acc) : int'(d1);
            m_flag   = (opv < av);
            m_result = BW'(opv - av);
            m_acc    = m_result;
            m_seeded = 1'b1;
            m_skip   = m_flag;
         end
      end
   endtask

   task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, got, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic e, input logic [BW-1:0] d0, input logic [BW-1:0] d1);
      @(negedge clk);
      bus.ena     = e;
      bus.data[0] = d0;
      bus.data[1] = d1;
      model_step(e, d0, d1);
      exp_q.push_back({m_state_code(), m_acc, m_result, m_flag});
   endtask

   task automatic drive_idle_random();
      drive(1'b0, BW'($urandom), BW'($urandom));
   endtask

   task automatic async_reset(input string name);
      @(negedge clk);
      bus.ena = 1'b0;
      #2 rst = 1'b0;
      #1;
      model_reset();
      check(name, {dbg_state, dbg_acc, bus.result, bus.flag},
            {2'd0, {BW{1'b0}}, {BW{1'b0}}, 1'b0});
      @(negedge clk);
      rst = 1'b1;
   endtask

   // monitor: compares whatever the DUT shows after each edge with the oldest expectation
   always @(posedge clk) begin
      logic [EW-1:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("cycle", {dbg_state, dbg_acc, bus.result, bus.flag}, e);
      end
   end

   initial begin
      rst         = 1'b0;
      bus.ena     = 1'b0;
      bus.data[0] = '0;
      bus.data[1] = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_values", {dbg_state, dbg_acc, bus.result, bus.flag},
            {2'd0, {BW{1'b0}}, {BW{1'b0}}, 1'b0});
      rst = 1'b1;

      // seed 1, op 0: borrow into SKIP
      drive(1'b1, 1'b0, 1'b1);
      // squashed, then 1 - 1 = 0
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      // back-to-back from acc=0
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      // borrow, three idle cycles, then a squashed offer
      drive(1'b1, 1'b0, 1'b0);
      repeat (3) drive_idle_random();
      drive(1'b1, 1'b1, 1'b0);
      // reach SKIP with acc=1, reset there, then reseed from data[1]
      drive(1'b1, 1'b0, 1'b0);
      async_reset("reset_in_skip");
      drive(1'b1, 1'b1, 1'b0);
      // idle with random data
      repeat (10) drive_idle_random();

      // random stream with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            async_reset("reset_random");
         end else begin
            drive(1'($urandom_range(0, 3) != 0), BW'($urandom), BW'($urandom));
         end
      end

      @(negedge clk);
      bus.ena = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
